sched_pool: RTL

Parametrised successor of the two-machine sporadic scheduling benchmark. It dispatches NT sporadic task types onto NM machines, each with a free-running internal phase counter, under controller-driven machine selection. Each machine's phase counter decides whether its job takes a short or a long number of ticks. The block is a synthesis benchmark: `controllable_*` inputs belong to the controller, and all other inputs are environment inputs. `error` is the sticky losing condition, and the `_rt_*` outputs expose the accepted real-time events.

---
 rtl/sched_pkg.sv | 24 ++
 rtl/sched_phase_counter.sv | 52 +++++
 rtl/sched_pool.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the sched_pool machine scheduler:
//   - task_id_t : task identifier for the default task count (0 = idle,
//                 type index i is carried as id i+1)
//   - IDLE_ID   : identifier of an unoccupied machine
//   - tap_index : which phase-counter bit machine m samples on every tick
// ---------------------------------------------------------------------------
package sched_pkg;

    localparam int NT_DEFAULT = 2;

    typedef logic [$clog2(NT_DEFAULT + 1)-1:0] task_id_t;

    localparam task_id_t IDLE_ID = '0;

    // Each machine looks at a different bit of its own phase counter so
    // that machines started together do not all choose the same job length.
    function automatic int unsigned tap_index(input int unsigned m,
                                              input int unsigned phaseW);
        return (3 * m) % phaseW;
    endfunction

endpackage

// File: rtl/sched_phase_counter.sv
// ---------------------------------------------------------------------------
// sched_phase_counter
// Free-running-on-demand phase counter owned by one machine. It advances by
// one (wrapping to 0 after PHASE_MAX) on every cycle its update flag is
// high, and exposes one selected bit that picks the short or long job.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   update in   advance the counter on this edge
//   tap    in   index of the bit presented on outbit
//   outbit out  phase[tap]
// ---------------------------------------------------------------------------
module sched_phase_counter
    import sched_pkg::*;
#(
    parameter int PHASE_W   = 10,
    parameter int PHASE_MAX = 64
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           update,
    input  logic [((PHASE_W > 1) ? $clog2(PHASE_W) : 1)-1:0] tap,
    output logic                                           outbit
);

    logic [PHASE_W-1:0] phase_q, phase_d;

    // Next phase: hold, or step with wrap once PHASE_MAX has been reached.
    always_comb begin
        phase_d = phase_q;
        if (update) begin
            if (phase_q < PHASE_W'(PHASE_MAX)) begin
                phase_d = phase_q + 1'b1;
            end else begin
                phase_d = '0;
            end
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign outbit = phase_q[tap];

endmodule

// File: rtl/sched_pool.sv
// ---------------------------------------------------------------------------
// sched_pool
// Dispatches NT sporadic task types onto NM machines. The controller picks
// the target machine through controllable_sel; the environment drives task
// arrivals (start) and call completions (tick). Only one event is accepted
// per cycle. Each job lasts NB_SHORT+1 or NB_LONG+1 ticks depending on a
// bit of the machine's phase counter, re-sampled on every tick. error is a
// sticky losing flag for the controller.
//
// Optional feature, enabled by defining SCHED_QUEUE_EN: arrivals with no
// machine selected are parked in a QD-entry FIFO and later dispatched onto
// an idle selected machine, instead of raising error immediately.
//
// Ports:
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   controllable_sel in   machine selection, lowest set index wins
//   start            in   task arrivals, lowest index has priority
//   tick             in   external call completed
//   error            out  sticky loss flag
//   _rt_start        out  accepted arrival (one-hot or zero)
//   _rt_tick         out  accepted tick
//   busy             out  per-machine occupancy
//   q_level          out  pending FIFO occupancy (0 without SCHED_QUEUE_EN)
// ---------------------------------------------------------------------------
module sched_pool
    import sched_pkg::*;
#(
    parameter int NM        = 3,
    parameter int NT        = 2,
    parameter int NB_SHORT  = 1,
    parameter int NB_LONG   = 2,
    parameter int PHASE_W   = 10,
    parameter int PHASE_MAX = 64,
    parameter int QD        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NM-1:0]             controllable_sel,
    input  logic [NT-1:0]             start,
    input  logic                      tick,
    output logic                      error,
    output logic [NT-1:0]             _rt_start,
    output logic                      _rt_tick,
    output logic [NM-1:0]             busy,
    output logic [$clog2(QD+1)-1:0]   q_level
);

    localparam int IdW   = $clog2(NT + 1);
    localparam int NbMax = (NB_LONG > NB_SHORT) ? NB_LONG : NB_SHORT;
    localparam int CntW  = (NbMax > 0) ? $clog2(NbMax + 1) : 1;
    localparam int QlW   = $clog2(QD + 1);
    localparam int TapW  = (PHASE_W > 1) ? $clog2(PHASE_W) : 1;

    localparam logic [CntW-1:0] ShortThr = CntW'(NB_SHORT);
    localparam logic [CntW-1:0] LongThr  = CntW'(NB_LONG);
    localparam logic [IdW-1:0]  IdleId   = IdW'(IDLE_ID);

    logic [IdW-1:0]  occ_q [NM];
    logic [IdW-1:0]  occ_d [NM];
    logic [CntW-1:0] cnt_q [NM];
    logic [CntW-1:0] cnt_d [NM];
    logic [NM-1:0]   update_q, update_d;
    logic            notfirst_q;
    logic            error_q, error_d;

    logic [NT-1:0]   rtStart;
    logic            rtTick;
    logic [IdW-1:0]  startId;
    logic            startFound;
    logic [NM-1:0]   selOneHot;
    logic [NM-1:0]   tapBit;

`ifdef SCHED_QUEUE_EN
    localparam int PtrW = (QD > 1) ? $clog2(QD) : 1;

    logic [IdW-1:0]  fifo_q [QD];
    logic [PtrW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [QlW-1:0]  count_q, count_d;
    logic            push, pop;

    function automatic logic [PtrW-1:0] ptrNext(input logic [PtrW-1:0] p);
        return (p == PtrW'(QD - 1)) ? '0 : p + 1'b1;
    endfunction
`endif

    // Event gating: the lowest pending arrival always blocks higher ones,
    // even when it is itself refused because of the first cycle or error.
    always_comb begin
        rtStart    = '0;
        startId    = IdleId;
        startFound = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if (start[i] && !startFound) begin
                startFound = 1'b1;
                if (notfirst_q && !error_q) begin
                    rtStart[i] = 1'b1;
                    startId    = IdW'(i + 1);
                end
            end
        end
    end

    assign rtTick    = notfirst_q && !(|rtStart) && tick;
    assign selOneHot = controllable_sel & (~controllable_sel + NM'(1));

    for (genvar m = 0; m < NM; m++) begin : g_busy
        assign busy[m] = (occ_q[m] != IdleId);
    end

    for (genvar m = 0; m < NM; m++) begin : g_phase
        localparam int TapIdx = tap_index(m, PHASE_W);
        sched_phase_counter #(
            .PHASE_W   (PHASE_W),
            .PHASE_MAX (PHASE_MAX)
        ) u_phase (
            .clk    (clk),
            .rst_n  (rst_n),
            .update (update_q[m]),
            .tap    (TapW'(TapIdx)),
            .outbit (tapBit[m])
        );
    end

    // Next-state logic. Tick accounting and the busy-selection check both
    // look at pre-edge occupancy, so a machine finishing on this tick still
    // counts as busy for the error rule.
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            occ_d[m] = occ_q[m];
            cnt_d[m] = cnt_q[m];
        end
        update_d = '0;
        error_d  = error_q;
`ifdef SCHED_QUEUE_EN
        push     = 1'b0;
        pop      = 1'b0;
        rdPtr_d  = rdPtr_q;
        wrPtr_d  = wrPtr_q;
        count_d  = count_q;
`endif

        if (notfirst_q && |(controllable_sel & busy)) begin
            error_d = 1'b1;
        end

        if (rtTick) begin
            for (int m = 0; m < NM; m++) begin
                if (busy[m]) begin
                    update_d[m] = 1'b1;
                    if (cnt_q[m] < (tapBit[m] ? ShortThr : LongThr)) begin
                        cnt_d[m] = cnt_q[m] + 1'b1;
                    end else begin
                        occ_d[m] = IdleId;
                        cnt_d[m] = '0;
                    end
                end
            end
        end

        if (|rtStart) begin
            if (|selOneHot) begin
                for (int m = 0; m < NM; m++) begin
                    if (selOneHot[m]) begin
                        occ_d[m] = startId;
                        cnt_d[m] = '0;
                    end
                end
            end else begin
`ifdef SCHED_QUEUE_EN
                if (count_q == QlW'(QD)) begin
                    error_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    wrPtr_d = ptrNext(wrPtr_q);
                end
`else
                error_d = 1'b1;
`endif
            end
        end

`ifdef SCHED_QUEUE_EN
        // Dispatch a parked task onto the selected machine when it is idle.
        if (!(|rtStart) && (count_q != '0) && |(selOneHot & ~busy)) begin
            pop     = 1'b1;
            rdPtr_d = ptrNext(rdPtr_q);
            for (int m = 0; m < NM; m++) begin
                if (selOneHot[m]) begin
                    occ_d[m] = fifo_q[rdPtr_q];
                    cnt_d[m] = '0;
                end
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
`endif
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NM; m++) begin
                occ_q[m] <= IdleId;
                cnt_q[m] <= '0;
            end
            update_q   <= '0;
            notfirst_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            for (int m = 0; m < NM; m++) begin
                occ_q[m] <= occ_d[m];
                cnt_q[m] <= cnt_d[m];
            end
            update_q   <= update_d;
            notfirst_q <= 1'b1;
            error_q    <= error_d;
        end
    end

`ifdef SCHED_QUEUE_EN
    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage needs no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wrPtr_q] <= startId;
        end
    end

    assign q_level = count_q;
`else
    assign q_level = '0;
`endif

    assign error     = error_q;
    assign _rt_start = rtStart;
    assign _rt_tick  = rtTick;

endmodule
